hazard_scoreboard: RTL



---
 rtl/hazard_scoreboard.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard/stall controller for the F/D/E/M/W pipeline: tracks dst/Tnew tags of E, M, W,
// derives D-stage stalls and forward selects, and times the multi-cycle mult/div unit.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int TW       = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              d_valid,
    input  logic              d_rs_used,
    input  logic [REG_AW-1:0] d_rs_addr,
    input  logic [TW-1:0]     d_rs_tuse,
    input  logic              d_rt_used,
    input  logic [REG_AW-1:0] d_rt_addr,
    input  logic [TW-1:0]     d_rt_tuse,
    input  logic [REG_AW-1:0] d_dst_addr,
    input  logic [TW-1:0]     d_tnew,
    input  logic              d_is_md,
    input  logic              d_md_start,
    input  logic              d_md_is_div,
    output logic              stall,
    output logic              e_flush,
    output logic [1:0]        fwd_rs_sel,
    output logic [1:0]        fwd_rt_sel,
    output logic              md_busy,
    output logic [REG_AW-1:0] e_dst,
    output logic [REG_AW-1:0] m_dst,
    output logic [REG_AW-1:0] w_dst,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    localparam logic [1:0] SEL_GRF = 2'd0;
    localparam logic [1:0] SEL_E   = 2'd1;
    localparam logic [1:0] SEL_M   = 2'd2;
    localparam logic [1:0] SEL_W   = 2'd3;

    logic [REG_AW-1:0] e_dst_r, m_dst_r, w_dst_r;
    logic [TW-1:0]     e_tnew_r, m_tnew_r, w_tnew_r;
    logic [MD_W-1:0]   md_cnt_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic              rs_haz_s, rt_haz_s, md_haz_s, stall_s, md_busy_s;
    logic [1:0]        rs_sel_s, rt_sel_s;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
        if (x == {TW{1'b0}}) begin
            return {TW{1'b0}};
        end else begin
            return x - TW'(1);
        end
    endfunction

    // Returns {hazard, fwd_sel}; only the youngest matching stage is considered.
    function automatic logic [2:0] src_eval(
        input logic              valid,
        input logic              used,
        input logic [REG_AW-1:0] addr,
        input logic [TW-1:0]     tuse,
        input logic [REG_AW-1:0] ed, input logic [TW-1:0] et,
        input logic [REG_AW-1:0] md, input logic [TW-1:0] mt,
        input logic [REG_AW-1:0] wd, input logic [TW-1:0] wt
    );
        logic          hit;
        logic [TW-1:0] tn;
        logic [1:0]    code;
        hit  = 1'b0;
        tn   = {TW{1'b0}};
        code = SEL_GRF;
        if (valid && used && (addr != {REG_AW{1'b0}})) begin
            if (ed == addr) begin
                hit = 1'b1; tn = et; code = SEL_E;
            end else if (md == addr) begin
                hit = 1'b1; tn = mt; code = SEL_M;
            end else if (wd == addr) begin
                hit = 1'b1; tn = wt; code = SEL_W;
            end else begin
                hit = 1'b0;
            end
        end else begin
            hit = 1'b0;
        end
        if (hit && (tn == {TW{1'b0}})) begin
            return {1'b0, code};
        end else if (hit && (tn > tuse)) begin
            return {1'b1, SEL_GRF};
        end else begin
            return {1'b0, SEL_GRF};
        end
    endfunction

    // Hazard detection and forward selection from the D-stage sources and stage tags.
    always_comb begin
        rs_haz_s = 1'b0;
        rs_sel_s = SEL_GRF;
        rt_haz_s = 1'b0;
        rt_sel_s = SEL_GRF;
        {rs_haz_s, rs_sel_s} = src_eval(d_valid, d_rs_used, d_rs_addr, d_rs_tuse,
                                        e_dst_r, e_tnew_r, m_dst_r, m_tnew_r, w_dst_r, w_tnew_r);
        {rt_haz_s, rt_sel_s} = src_eval(d_valid, d_rt_used, d_rt_addr, d_rt_tuse,
                                        e_dst_r, e_tnew_r, m_dst_r, m_tnew_r, w_dst_r, w_tnew_r);
        md_busy_s = (md_cnt_r != {MD_W{1'b0}});
        md_haz_s  = d_valid & d_is_md & md_busy_s;
        stall_s   = rs_haz_s | rt_haz_s | md_haz_s;
    end

    // Stage tag shift pipeline; a stalled or empty D inserts a null tag into E.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_dst_r  <= {REG_AW{1'b0}};
            e_tnew_r <= {TW{1'b0}};
            m_dst_r  <= {REG_AW{1'b0}};
            m_tnew_r <= {TW{1'b0}};
            w_dst_r  <= {REG_AW{1'b0}};
            w_tnew_r <= {TW{1'b0}};
        end else begin
            w_dst_r  <= m_dst_r;
            w_tnew_r <= sat_dec(m_tnew_r);
            m_dst_r  <= e_dst_r;
            m_tnew_r <= sat_dec(e_tnew_r);
            if (stall_s || !d_valid) begin
                e_dst_r  <= {REG_AW{1'b0}};
                e_tnew_r <= {TW{1'b0}};
            end else begin
                e_dst_r  <= d_dst_addr;
                e_tnew_r <= d_tnew;
            end
        end
    end

    // Mult/div busy counter; a start while busy is stalled, so load never meets decrement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt_r <= {MD_W{1'b0}};
        end else if (d_valid && d_md_start && !stall_s) begin
            md_cnt_r <= d_md_is_div ? MD_W'(DIV_CYC) : MD_W'(MULT_CYC);
        end else if (md_busy_s) begin
            md_cnt_r <= md_cnt_r - MD_W'(1);
        end else begin
            md_cnt_r <= md_cnt_r;
        end
    end

    // Saturating stalled-cycle performance counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall      = stall_s;
    assign e_flush    = stall_s;
    assign fwd_rs_sel = rs_sel_s;
    assign fwd_rt_sel = rt_sel_s;
    assign md_busy    = md_busy_s;
    assign e_dst      = e_dst_r;
    assign m_dst      = m_dst_r;
    assign w_dst      = w_dst_r;
    assign stall_cnt  = stall_cnt_r;

endmodule
